mor1kx_branch_resolve_tracker: RTL and testbench

//  Sits downstream of the branch predictor, between decode and execute. Captures

---
 rtl/mor1kx_branch_resolve_tracker.sv | 73 +++++++
 tb/tb_mor1kx_branch_resolve_tracker.sv | 108 ++++++++++
 2 files changed

// File: rtl/mor1kx_branch_resolve_tracker.sv
// mor1kx_branch_resolve_tracker: holds a decoded bf/bnf and its prediction until the flag resolves in execute.
// Optional saturating statistics counters are built when MOR1KX_BRANCH_STATS_EN is defined.
module mor1kx_branch_resolve_tracker #(
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  padv_decode_i,
  input  logic                  op_bf_i,
  input  logic                  op_bnf_i,
  input  logic                  predicted_flag_i,
  input  logic                  pipeline_flush_i,
  input  logic                  flag_valid_i,
  input  logic                  flag_i,
  output logic                  execute_op_bf_o,
  output logic                  execute_op_bnf_o,
  output logic                  prev_op_brcond_o,
  output logic                  execute_pred_flag_o,
  output logic                  branch_mispredict_o,
  input  logic                  stat_clear_i,
  output logic [STAT_WIDTH-1:0] stat_branches_o,
  output logic [STAT_WIDTH-1:0] stat_mispredicts_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESOLVED} state_t;
  state_t state, state_nx;
  logic bf_q, bnf_q, pred_q;
  logic is_br, resolve;
  assign is_br = op_bf_i | op_bnf_i;
  assign resolve = (state == WAIT) & flag_valid_i & ~pipeline_flush_i;
  always_comb begin
    state_nx = state;
    state_nx = pipeline_flush_i ? IDLE :
               padv_decode_i    ? (is_br ? WAIT : IDLE) :
               resolve          ? RESOLVED : state;
  end
  always_ff @(posedge clk) begin
    if (rst || pipeline_flush_i) begin
      state  <= IDLE;
      bf_q   <= 1'b0;
      bnf_q  <= 1'b0;
      pred_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (padv_decode_i) begin
        bf_q   <= op_bf_i;
        bnf_q  <= op_bnf_i & ~op_bf_i;
        pred_q <= predicted_flag_i & is_br;
      end
    end
  end
  assign execute_op_bf_o     = bf_q;
  assign execute_op_bnf_o    = bnf_q;
  assign prev_op_brcond_o    = bf_q | bnf_q;
  assign execute_pred_flag_o = pred_q;
  assign branch_mispredict_o = resolve & (flag_i != pred_q);
`ifdef MOR1KX_BRANCH_STATS_EN
  logic [STAT_WIDTH-1:0] br_cnt, mis_cnt;
  always_ff @(posedge clk) begin
    if (rst || stat_clear_i) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      if (resolve && !(&br_cnt)) br_cnt <= br_cnt + 1'b1;
      if (branch_mispredict_o && !(&mis_cnt)) mis_cnt <= mis_cnt + 1'b1;
    end
  end
  assign stat_branches_o    = br_cnt;
  assign stat_mispredicts_o = mis_cnt;
`else
  assign stat_branches_o    = {STAT_WIDTH{1'b0 & stat_clear_i}};
  assign stat_mispredicts_o = '0;
`endif
endmodule

// File: tb/tb_mor1kx_branch_resolve_tracker.sv
// tb_mor1kx_branch_resolve_tracker: directed vectors feed a scoreboard queue checked by a negedge monitor.
module tb_mor1kx_branch_resolve_tracker;
  localparam int W = 4;
`ifdef MOR1KX_BRANCH_STATS_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic padv = 1'b0, bf = 1'b0, bnf = 1'b0, pred = 1'b0, flush = 1'b0, fv = 1'b0, flag = 1'b0, clr = 1'b0;
  logic o_bf, o_bnf, o_br, o_pred, o_mis;
  logic [W-1:0] s_br, s_mis;
  typedef struct {
    logic [4:0] e;
    logic cs;
    logic [W-1:0] eb, em;
    int id;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, vid = 0;
  always #5 clk = ~clk;
  mor1kx_branch_resolve_tracker #(.STAT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .padv_decode_i(padv), .op_bf_i(bf), .op_bnf_i(bnf),
    .predicted_flag_i(pred), .pipeline_flush_i(flush), .flag_valid_i(fv), .flag_i(flag),
    .execute_op_bf_o(o_bf), .execute_op_bnf_o(o_bnf), .prev_op_brcond_o(o_br),
    .execute_pred_flag_o(o_pred), .branch_mispredict_o(o_mis), .stat_clear_i(clr),
    .stat_branches_o(s_br), .stat_mispredicts_o(s_mis)
  );
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      logic [4:0] a;
      x = q.pop_front();
      a = {o_bf, o_bnf, o_br, o_pred, o_mis};
      checks++;
      if (a !== x.e) begin
        errors++;
        $display("FAIL vec%0d outputs {bf,bnf,brcond,pred,mis}: got %b expected %b", x.id, a, x.e);
      end
      if (x.cs) begin
        checks++;
        if (s_br !== x.eb || s_mis !== x.em) begin
          errors++;
          $display("FAIL vec%0d stats: got br=%0d mis=%0d expected br=%0d mis=%0d", x.id, s_br, s_mis, x.eb, x.em);
        end
      end
    end
  end
  task automatic v(input logic i_padv, i_bf, i_bnf, i_pred, i_flush, i_fv, i_flag, i_clr,
                   input logic [4:0] e, input logic cs = 1'b0,
                   input logic [W-1:0] eb = '0, input logic [W-1:0] em = '0);
    exp_t x;
    @(posedge clk);
    #1;
    padv = i_padv; bf = i_bf; bnf = i_bnf; pred = i_pred;
    flush = i_flush; fv = i_fv; flag = i_flag; clr = i_clr;
    x.e = e; x.cs = cs; x.eb = SE ? eb : '0; x.em = SE ? em : '0; x.id = vid++;
    q.push_back(x);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    //  padv bf bnf pred flush fv flag clr  {bf,bnf,br,pred,mis}
    v(1,1,0,1,0,0,0,0, 5'b00000);
    v(0,0,0,0,0,1,1,0, 5'b10110);
    v(0,0,0,0,0,0,0,0, 5'b10110);
    v(1,0,1,0,0,0,0,0, 5'b10110);
    v(0,0,0,0,0,1,1,0, 5'b01101);
    v(0,0,0,0,0,1,1,0, 5'b01100);
    v(0,0,0,0,0,1,1,0, 5'b01100);
    v(0,0,0,0,0,0,0,0, 5'b01100);
    v(1,0,0,1,0,0,0,0, 5'b01100);
    v(0,0,0,0,0,0,0,0, 5'b00000);
    v(0,0,0,0,0,1,1,0, 5'b00000);
    v(1,1,0,1,0,0,0,0, 5'b00000);
    v(1,1,0,1,1,1,0,0, 5'b10110);
    v(0,0,0,0,0,0,0,0, 5'b00000);
    v(0,0,0,0,0,1,0,0, 5'b00000);
    v(1,1,0,1,0,0,0,0, 5'b00000);
    v(1,1,0,0,0,1,0,0, 5'b10111);
    v(0,0,0,0,0,0,0,0, 5'b10100);
    v(0,0,0,0,0,1,0,0, 5'b10100);
    v(1,1,1,1,0,0,0,0, 5'b10100);
    v(0,0,0,0,0,1,0,0, 5'b10111);
    v(1,0,1,1,0,0,0,0, 5'b10110);
    v(1,1,0,0,0,0,0,0, 5'b01110);
    v(0,0,0,0,0,1,1,0, 5'b10101);
    v(0,0,0,0,0,0,0,1, 5'b10100, 1'b1, 4'd6, 4'd4);
    v(0,0,0,0,0,0,0,0, 5'b10100, 1'b1, 4'd0, 4'd0);
    for (int k = 0; k < 17; k++) begin
      v(1,1,0,1,0,0,0,0, (k == 0) ? 5'b10100 : 5'b10110);
      v(0,0,0,0,0,1,0,0, 5'b10111);
    end
    v(0,0,0,0,0,0,0,0, 5'b10110, 1'b1, 4'd15, 4'd15);
    v(1,1,0,1,0,0,0,0, 5'b10110);
    v(0,0,0,0,0,1,0,1, 5'b10111, 1'b1, 4'd15, 4'd15);
    v(0,0,0,0,0,0,0,0, 5'b10110, 1'b1, 4'd0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
